// File: rtl/mppt_pkg.sv
// MPPT phase sequencer shared types and default parameter constants.
// Imported by mppt_seq and mppt_seq_cnt.
package mppt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int CNT_W_DEF  = 14;
    localparam int SETTLE_DEF = 12500;
    localparam int N_CH_DEF   = 4;
    localparam int ITER_W_DEF = 16;

endpackage

// File: rtl/mppt_seq_cnt.sv
// Per-phase settle counter: counts 0..SETTLE-1 and wraps,
// tc flags the last cycle of the phase.
module mppt_seq_cnt
    import mppt_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == CNT_W'(SETTLE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mppt_seq.sv
// MPPT phase sequencer: steps one-hot enables through N_CH phases.
// Define MPPT_SEQ_HOLD_EN to enable the HOLD state driven by the hold input.
module mppt_seq
    import mppt_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int ITER_W = ITER_W_DEF,
    localparam int PH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              hold,
    input  logic              abort,
    output logic [N_CH-1:0]   en,
    output logic [PH_W-1:0]   phase,
    output logic [CNT_W-1:0]  c_i,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] n_iter
);

    state_t            state;
    state_t            state_d;
    logic [PH_W-1:0]   phase_d;
    logic [N_CH-1:0]   en_d;
    logic              busy_d;
    logic              done_d;
    logic              hold_req;
    logic              cnt_clr;
    logic              cnt_en;
    logic              tc;
    logic              last;
    logic              step;

`ifdef MPPT_SEQ_HOLD_EN
    assign hold_req = hold;
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign hold_req    = 1'b0;
`endif

    assign last    = (phase == PH_W'(N_CH - 1));
    assign cnt_clr = (state == ST_IDLE) || abort;
    assign cnt_en  = (state == ST_RUN) && !abort && !hold_req;
    assign step    = cnt_en && tc;

    mppt_seq_cnt #(
        .CNT_W  (CNT_W),
        .SETTLE (SETTLE)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (c_i),
        .tc    (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            phase  <= '0;
            en     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            n_iter <= '0;
        end else begin
            state  <= state_d;
            phase  <= phase_d;
            en     <= en_d;
            busy   <= busy_d;
            done   <= done_d;
            n_iter <= n_iter + ITER_W'(done_d);
        end
    end

    // abort outranks hold, which outranks the terminal count
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (abort)            state_d = ST_IDLE;
                else if (hold_req)    state_d = ST_HOLD;
                else if (tc && last)  state_d = cont ? ST_RUN : ST_IDLE;
            end
`ifdef MPPT_SEQ_HOLD_EN
            ST_HOLD: begin
                if (abort)          state_d = ST_IDLE;
                else if (!hold_req) state_d = ST_RUN;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        phase_d = phase;
        if (state_d == ST_IDLE) begin
            phase_d = '0;
        end else if (step) begin
            phase_d = last ? '0 : phase + 1'b1;
        end
        done_d = step && last;
        busy_d = (state_d != ST_IDLE);
        en_d   = (state_d == ST_RUN) ? (N_CH'(1) << phase_d) : '0;
    end

endmodule
